uart_rx: RTL and testbench

UART receive block: the serial-to-parallel counterpart of the team's UART transmit control path. It samples the asynchronous `rx` line at mid-bit and assembles an 8N1 frame, LSB first. It presents each received byte with a single-cycle valid strobe and flags framing (and optionally parity) errors. It contains both the control FSM and the datapath: synchronizer, baud counter, shift register and bit counter.

---
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver, start + DATA_W data bits (LSB first) + stop.
//   Samples the synchronized line at mid-bit and presents each good byte
//   with a one-cycle valid strobe. A stop bit sampled low flags a framing
//   error. The receiver then waits for the line to return high before it
//   accepts a new start bit.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
//   between the data bits and the stop bit. This enables parity_err.
//
// Parameters
//   BAUD_DIV   clocks per bit period (>= 4)
//   DATA_W     data bits per frame (>= 2)
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   rx          serial line, idle high, asynchronous to clk
//   rx_data     last correctly framed byte, held until the next one
//   rx_valid    one-cycle pulse when rx_data updates
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   parity_err  one-cycle pulse on parity mismatch (0 without the macro)
//   rx_busy     high whenever the FSM is not idle
module uart_rx #(
  parameter int BAUD_DIV = 434,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              rx_busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BAUD_M1  = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  state_e             state_q, state_d;
  logic               rx_meta_q, rx_s_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               tick;
`ifdef UART_RX_PARITY_EN
  logic               par_q, par_d;
  logic               parity_err_q, parity_err_d;
`endif

  // Sample point: half a bit into the start bit, then a full bit thereafter.
  assign tick = (state_q == S_START) ? (cnt_q == HALF_M1) : (cnt_q == BAUD_M1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath registers. The synchronizer resets high so that reset is not
  // mistaken for a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line high again at mid start bit was only a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          // LSB arrives first: shift in at the top so it ends at bit 0.
          shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
          par_d   = rx_s_q;
`endif
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_BREAK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        // A line held low after a bad stop is not a new start bit.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pulses are set up here and registered, so they land in the
  // cycle after the stop-bit sample.
  always_comb begin
    rx_busy     = (state_q != S_IDLE);
    rx_valid_d  = (state_q == S_STOP) && tick && rx_s_q;
    frame_err_d = (state_q == S_STOP) && tick && !rx_s_q;
    rx_data_d   = rx_valid_d ? shift_q : rx_data_q;
`ifdef UART_RX_PARITY_EN
    // Even parity: data bits and parity bit XOR to zero on a clean frame.
    parity_err_d = rx_valid_d && (^{shift_q, par_q});
`endif
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BAUD_DIV = 16. The bench drives frames on the
// falling edge and logs output pulses with cycle stamps on the falling edge.
// It compares the logged pulses with expectations built from the frame
// contents and the bit timing of the protocol.
module tb_uart_rx;
  localparam int BD = 16;
  localparam int DW = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  // From the driven rx fall: 2 synchronizer cycles, half a bit to the start
  // sample, then one bit period for each following bit up to the stop bit.
  // One more cycle is added for the registered pulse.
  localparam int LAT = 3 + BD/2 + (NBITS-1)*BD;

  logic clk = 1'b0, rst = 1'b0, rx = 1'b1;
  logic [DW-1:0] rx_data;
  logic rx_valid, frame_err, parity_err, rx_busy;

  uart_rx #(.BAUD_DIV(BD), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .parity_err(parity_err), .rx_busy(rx_busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [DW-1:0] vdata[$];
  int vcyc[$], fcyc[$], pcyc[$];
  logic vbusy[$];
  int last_fall;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always @(negedge clk) begin
    if (rx_valid) begin vdata.push_back(rx_data); vcyc.push_back(cyc); vbusy.push_back(rx_busy); end
    if (frame_err) fcyc.push_back(cyc);
    if (parity_err) pcyc.push_back(cyc);
  end

  task clear_mon;
    vdata.delete(); vcyc.delete(); vbusy.delete(); fcyc.delete(); pcyc.delete();
  endtask

  task drive_bit(input logic b);
    rx = b;
    repeat (BD) @(negedge clk);
  endtask

  task send_frame(input logic [DW-1:0] d, input logic stop);
    last_fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop);
  endtask

  task idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task check_outputs_zero(input string tag);
    checks++; if (rx_data !== '0) begin errors++; $display("FAIL %s rx_data got %h exp 00", tag, rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL %s rx_valid got %b exp 0", tag, rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL %s frame_err got %b exp 0", tag, frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL %s parity_err got %b exp 0", tag, parity_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL %s rx_busy got %b exp 0", tag, rx_busy); end
  endtask

  task test_reset;
    rst = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_idle rx_busy got %b exp 0", rx_busy); end
  endtask

  task test_single;
    clear_mon();
    send_frame(8'hA5, 1'b1);
    idle(2*BD);
    checks++;
    if (vdata.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", vdata.size()); end
    else begin
      checks++; if (vdata[0] !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", vdata[0]); end
      checks++; if (vcyc[0] - last_fall != LAT) begin errors++; $display("FAIL single_latency got %0d exp %0d", vcyc[0]-last_fall, LAT); end
      checks++; if (vbusy[0] !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", vbusy[0]); end
    end
    checks++; if (fcyc.size() != 0) begin errors++; $display("FAIL single_ferr got %0d exp 0", fcyc.size()); end
    checks++; if (pcyc.size() != 0) begin errors++; $display("FAIL single_perr got %0d exp 0", pcyc.size()); end
  endtask

  task test_glitch;
    int bc;
    clear_mon();
    bc = 0;
    rx = 1'b0;
    repeat (4) begin @(negedge clk); bc += int'(rx_busy); end
    rx = 1'b1;
    repeat (40) begin @(negedge clk); bc += int'(rx_busy); end
    checks++; if (bc < 1 || bc > BD/2) begin errors++; $display("FAIL glitch_busy_cycles got %0d exp 1..%0d", bc, BD/2); end
    checks++; if (vdata.size() + fcyc.size() + pcyc.size() != 0) begin errors++; $display("FAIL glitch_pulses got %0d exp 0", vdata.size()+fcyc.size()+pcyc.size()); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL glitch_data got %h exp a5", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b exp 0", rx_busy); end
  endtask

  task test_frame_err;
    int not_busy;
    clear_mon();
    send_frame(8'h3C, 1'b0);
    not_busy = 0;
    repeat (40) begin @(negedge clk); if (!rx_busy) not_busy++; end
    idle(2*BD);
    checks++;
    if (fcyc.size() != 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", fcyc.size()); end
    else begin
      checks++; if (fcyc[0] - last_fall != LAT) begin errors++; $display("FAIL ferr_latency got %0d exp %0d", fcyc[0]-last_fall, LAT); end
    end
    checks++; if (vdata.size() != 0) begin errors++; $display("FAIL ferr_valid got %0d exp 0", vdata.size()); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_data got %h exp a5", rx_data); end
    checks++; if (not_busy != 0) begin errors++; $display("FAIL ferr_break_busy got %0d idle cycles exp 0", not_busy); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_idle got %b exp 0", rx_busy); end
  endtask

  task test_back_to_back;
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2*BD);
    checks++;
    if (vdata.size() != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", vdata.size()); end
    else begin
      checks++; if (vdata[0] !== 8'h00) begin errors++; $display("FAIL b2b_data0 got %h exp 00", vdata[0]); end
      checks++; if (vdata[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1 got %h exp ff", vdata[1]); end
      checks++; if (vcyc[1] - vcyc[0] != NBITS*BD) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", vcyc[1]-vcyc[0], NBITS*BD); end
    end
    checks++; if (fcyc.size() != 0) begin errors++; $display("FAIL b2b_ferr got %0d exp 0", fcyc.size()); end
  endtask

  task test_reset_mid;
    logic [7:0] d;
    clear_mon();
    d = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (BD/2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_mid");
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    idle(3*BD);
    checks++; if (vdata.size() + fcyc.size() + pcyc.size() != 0) begin errors++; $display("FAIL abort_pulses got %0d exp 0", vdata.size()+fcyc.size()+pcyc.size()); end
    send_frame(8'h81, 1'b1);
    idle(2*BD);
    checks++;
    if (vdata.size() != 1) begin errors++; $display("FAIL after_reset_count got %0d exp 1", vdata.size()); end
    else begin
      checks++; if (vdata[0] !== 8'h81) begin errors++; $display("FAIL after_reset_data got %h exp 81", vdata[0]); end
    end
  endtask

  task test_random;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] d;
    logic stop;
    int exp_ferr, exp_perr;
    clear_mon();
    exp_ferr = 0; exp_perr = 0;
    for (int n = 0; n < 10; n++) begin
      d = DW'($urandom);
      stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      par_flip = 1'($urandom_range(0, 1));
      if (stop && par_flip) exp_perr++;
`endif
      send_frame(d, stop);
      if (stop) exp_q.push_back(d); else exp_ferr++;
      idle($urandom_range(BD, 3*BD));
    end
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    idle(2*BD);
    checks++;
    if (vdata.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", vdata.size(), exp_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        checks++; if (vdata[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h", i, vdata[i], exp_q[i]); end
      end
    end
    checks++; if (fcyc.size() != exp_ferr) begin errors++; $display("FAIL rand_ferr got %0d exp %0d", fcyc.size(), exp_ferr); end
    checks++; if (pcyc.size() != exp_perr) begin errors++; $display("FAIL rand_perr got %0d exp %0d", pcyc.size(), exp_perr); end
  endtask

`ifdef UART_RX_PARITY_EN
  task test_parity;
    clear_mon();
    par_flip = 1'b1;
    send_frame(8'h03, 1'b1);
    par_flip = 1'b0;
    idle(2*BD);
    checks++;
    if (vdata.size() != 1 || pcyc.size() != 1) begin errors++; $display("FAIL par_bad_count got valid=%0d perr=%0d exp 1/1", vdata.size(), pcyc.size()); end
    else begin
      checks++; if (vdata[0] !== 8'h03) begin errors++; $display("FAIL par_bad_data got %h exp 03", vdata[0]); end
      checks++; if (pcyc[0] != vcyc[0]) begin errors++; $display("FAIL par_bad_align got %0d exp %0d", pcyc[0], vcyc[0]); end
    end
    clear_mon();
    send_frame(8'h03, 1'b1);
    idle(2*BD);
    checks++; if (vdata.size() != 1) begin errors++; $display("FAIL par_good_count got %0d exp 1", vdata.size()); end
    checks++; if (pcyc.size() != 0) begin errors++; $display("FAIL par_good_perr got %0d exp 0", pcyc.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
